// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared types and scan-code constants for the PS/2-to-MC10 key matrix
package ps2_key_pkg;
  localparam int IDX_W = 4;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_ALT = 8'h11;
  localparam logic [7:0] SC_CAPS = 8'h58;
  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP} state_t;
  typedef enum logic [1:0] {PASS, FORCE0, FORCE1} shift_mode_t;
  typedef struct packed {
    logic valid;
    logic [7:0] code;
    logic ext;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    shift_mode_t mode;
    logic ctrl_force;
  } slot_t;
  function automatic logic is_filler(input logic [7:0] c);
    return c inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00};
  endfunction
endpackage

// File: rtl/ps2_key_matrix_scan_lookup.sv
// scan_lookup: PS/2 set-2 code to MC10 matrix position (index = col*8 + row)
module scan_lookup
  import ps2_key_pkg::*;
(
  input  logic [7:0] code,
  input  logic ext,
  input  logic shift_phys,
  output logic hit,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output shift_mode_t mode,
  output logic ctrl_force
);
  logic [5:0] idx;
  shift_mode_t dig_mode;
  assign dig_mode = shift_phys ? FORCE1 : FORCE0;
  assign row = IDX_W'(idx[2:0]);
  assign col = IDX_W'(idx[5:3]);
  always_comb begin
    hit = 1'b1;
    idx = '0;
    mode = PASS;
    ctrl_force = 1'b0;
    if (ext)
      case (code)
        8'h75: begin idx = 6'd23; ctrl_force = 1'b1; end
        8'h6B: begin idx = 6'd1; ctrl_force = 1'b1; end
        8'h72: begin idx = 6'd26; ctrl_force = 1'b1; end
        8'h74: begin idx = 6'd19; ctrl_force = 1'b1; end
        8'h5A: idx = 6'd30;
        8'h4A: idx = 6'd47;
        default: hit = 1'b0;
      endcase
    else
      case (code)
        8'h1C: idx = 6'd1;
        8'h32: idx = 6'd2;
        8'h21: idx = 6'd3;
        8'h23: idx = 6'd4;
        8'h24: idx = 6'd5;
        8'h2B: idx = 6'd6;
        8'h34: idx = 6'd7;
        8'h33: idx = 6'd8;
        8'h43: idx = 6'd9;
        8'h3B: idx = 6'd10;
        8'h42: idx = 6'd11;
        8'h4B: idx = 6'd12;
        8'h3A: idx = 6'd13;
        8'h31: idx = 6'd14;
        8'h44: idx = 6'd15;
        8'h4D: idx = 6'd16;
        8'h15: idx = 6'd17;
        8'h2D: idx = 6'd18;
        8'h1B: idx = 6'd19;
        8'h2C: idx = 6'd20;
        8'h3C: idx = 6'd21;
        8'h2A: idx = 6'd22;
        8'h1D: idx = 6'd23;
        8'h22: idx = 6'd24;
        8'h35: idx = 6'd25;
        8'h1A: idx = 6'd26;
        8'h5A: idx = 6'd30;
        8'h29: idx = 6'd31;
        8'h66: begin idx = 6'd1; ctrl_force = 1'b1; end
        8'h45: begin idx = 6'd32; mode = dig_mode; end
        8'h16: begin idx = 6'd33; mode = dig_mode; end
        8'h1E: begin idx = shift_phys ? 6'd0 : 6'd34; mode = FORCE0; end
        8'h26: begin idx = 6'd35; mode = dig_mode; end
        8'h25: begin idx = 6'd36; mode = dig_mode; end
        8'h2E: begin idx = 6'd37; mode = dig_mode; end
        8'h36: begin idx = 6'd38; mode = dig_mode; end
        8'h3D: begin idx = 6'd39; mode = dig_mode; end
        8'h3E: begin idx = 6'd40; mode = dig_mode; end
        8'h46: begin idx = 6'd41; mode = dig_mode; end
        8'h4C: begin idx = shift_phys ? 6'd42 : 6'd43; mode = FORCE0; end
        8'h41: idx = 6'd44;
        8'h4E: idx = 6'd45;
        8'h49: idx = 6'd46;
        8'h4A: idx = 6'd47;
        default: hit = 1'b0;
      endcase
  end
endmodule

// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: PS/2 scan-code stream to MC10 active-low keyboard matrix with rollover
module ps2_key_matrix
  import ps2_key_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int SLOTS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [7:0] scan_code,
  input  logic scan_valid,
  input  logic flush,
  input  logic [COLS-1:0] col_sel_n,
  output logic [ROWS-1:0] row_n,
  output logic shift_n,
  output logic control_n,
  output logic caps_led,
  output logic overflow
);
  state_t state, state_nx;
  logic [2:0] skip_cnt, skip_nx;
  logic make_ev, brk_ev, ev_ext, clr, is_mod;
  logic lshift, rshift, lctrl, rctrl, lalt, ralt, caps_lock, caps_held;
  logic shift_phys, caps_eff, shift, ctrl_any;
  logic lk_hit, lk_cf;
  logic [IDX_W-1:0] lk_row, lk_col;
  shift_mode_t lk_mode;
  slot_t slots [SLOTS];
  slot_t new_slot;
  logic [SLOTS-1:0] free_vec, free_oh, match;
  assign clr = !reset_n || flush;
  assign shift_phys = lshift | rshift;
  assign caps_eff = shift_phys ^ caps_lock;
  assign is_mod = scan_code inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT} || (!ev_ext && scan_code == SC_CAPS);
  assign new_slot = '{1'b1, scan_code, ev_ext, lk_row, lk_col, lk_mode, lk_cf};
  assign free_oh = free_vec & (~free_vec + SLOTS'(1));
  assign shift_n = ~shift;
  assign control_n = ~(lctrl | rctrl | lalt | ralt | ctrl_any);
  assign caps_led = caps_lock;
  scan_lookup u_lookup (
    .code(scan_code),
    .ext(ev_ext),
    .shift_phys(shift_phys),
    .hit(lk_hit),
    .row(lk_row),
    .col(lk_col),
    .mode(lk_mode),
    .ctrl_force(lk_cf)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state <= state_nx;
      skip_cnt <= skip_nx;
    end
  end
  always_comb begin
    state_nx = state;
    skip_nx = skip_cnt;
    make_ev = 1'b0;
    brk_ev = 1'b0;
    ev_ext = 1'b0;
    if (scan_valid)
      case (state)
        ST_IDLE:
          if (scan_code == SC_E0) state_nx = ST_EXT;
          else if (scan_code == SC_F0) state_nx = ST_BRK;
          else if (scan_code == SC_E1) begin
            state_nx = ST_SKIP;
            skip_nx = 3'd7;
          end else make_ev = !is_filler(scan_code);
        ST_EXT: begin
          ev_ext = 1'b1;
          if (scan_code == SC_F0) state_nx = ST_EXT_BRK;
          else if (scan_code != SC_E0 && scan_code != SC_E1) begin
            make_ev = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_ev = 1'b1;
          state_nx = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_ev = 1'b1;
          ev_ext = 1'b1;
          state_nx = ST_IDLE;
        end
        ST_SKIP: begin
          skip_nx = skip_cnt - 3'd1;
          state_nx = skip_cnt == 3'd1 ? ST_IDLE : ST_SKIP;
        end
        default: state_nx = ST_IDLE;
      endcase
  end
  always_comb begin
    free_vec = '0;
    match = '0;
    for (int i = 0; i < SLOTS; i++) begin
      free_vec[i] = !slots[i].valid;
      match[i] = slots[i].valid && slots[i].code == scan_code && slots[i].ext == ev_ext;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      {lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held, overflow} <= '0;
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
      if (!reset_n) caps_lock <= 1'b0;
    end else begin
      if ((make_ev || brk_ev) && !ev_ext) begin
        if (scan_code == SC_LSHIFT) lshift <= make_ev;
        if (scan_code == SC_RSHIFT) rshift <= make_ev;
        if (scan_code == SC_CTRL) lctrl <= make_ev;
        if (scan_code == SC_ALT) lalt <= make_ev;
        if (scan_code == SC_CAPS) begin
          caps_held <= make_ev;
          if (make_ev && !caps_held) caps_lock <= ~caps_lock;
        end
      end
      if ((make_ev || brk_ev) && ev_ext) begin
        if (scan_code == SC_CTRL) rctrl <= make_ev;
        if (scan_code == SC_ALT) ralt <= make_ev;
      end
      if (make_ev && !is_mod && lk_hit && match == '0) begin
        if (free_vec == '0) overflow <= 1'b1;
        for (int i = 0; i < SLOTS; i++)
          if (free_oh[i]) slots[i] <= new_slot;
      end
      if (brk_ev && !is_mod)
        for (int i = 0; i < SLOTS; i++)
          if (match[i]) slots[i].valid <= 1'b0;
    end
  end
  // lowest-index slot with a forcing mode wins, hence the descending scan
  always_comb begin
    shift = caps_eff;
    ctrl_any = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slots[i].valid && slots[i].mode != PASS) shift = slots[i].mode == FORCE1;
      ctrl_any = ctrl_any | (slots[i].valid & slots[i].ctrl_force);
    end
  end
  always_comb begin
    row_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int i = 0; i < SLOTS; i++)
          if (slots[i].valid && slots[i].row == IDX_W'(r) && slots[i].col == IDX_W'(c) && !col_sel_n[c])
            row_n[r] = 1'b0;
  end
endmodule

// File: tb/tb_ps2_key_matrix.sv
// tb_ps2_key_matrix: directed scan-code sequences checked against hand-computed matrix outputs
module tb_ps2_key_matrix;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] scan_code;
  logic scan_valid;
  logic flush;
  logic [7:0] col_sel_n;
  logic [7:0] row_n;
  logic shift_n, control_n, caps_led, overflow;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  ps2_key_matrix #(.ROWS(8), .COLS(8), .SLOTS(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .scan_code(scan_code),
    .scan_valid(scan_valid),
    .flush(flush),
    .col_sel_n(col_sel_n),
    .row_n(row_n),
    .shift_n(shift_n),
    .control_n(control_n),
    .caps_led(caps_led),
    .overflow(overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1 scan_valid = 1'b0;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask
  task automatic row_at(input string tag, input logic [7:0] cols, input logic [7:0] exp);
    col_sel_n = cols;
    #1 check(tag, row_n, exp);
  endtask
  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    scan_valid = 1'b0;
    scan_code = 8'h00;
    col_sel_n = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_row", row_n, 8'hFF);
    check("rst_shift", shift_n, 1'b1);
    check("rst_ctrl", control_n, 1'b1);
    check("rst_caps", caps_led, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    send(8'h1C);
    row_at("a_col0", 8'hFE, 8'hFD);
    row_at("a_col1", 8'hFD, 8'hFF);
    check("a_shift", shift_n, 1'b1);
    send(8'hF0); send(8'h1C);
    row_at("a_brk", 8'h00, 8'hFF);
    send(8'h12);
    check("lshift", shift_n, 1'b0);
    send(8'h1E);
    row_at("at_col0", 8'hFE, 8'hFE);
    check("at_force0", shift_n, 1'b1);
    send(8'hF0); send(8'h12);
    row_at("at_after_shift_rel", 8'hFE, 8'hFE);
    check("at_shift_rel", shift_n, 1'b1);
    send(8'hF0); send(8'h1E);
    row_at("at_brk", 8'h00, 8'hFF);
    check("no_shift", shift_n, 1'b1);
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    check("caps_on", caps_led, 1'b1);
    check("caps_shift", shift_n, 1'b0);
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    row_at("ovf_col0", 8'hFE, 8'hE1);
    check("ovf_set", overflow, 1'b1);
    do_flush();
    row_at("flush_row", 8'h00, 8'hFF);
    check("flush_ovf", overflow, 1'b0);
    check("flush_caps", caps_led, 1'b1);
    send(8'h58);
    check("caps_off", caps_led, 1'b0);
    send(8'hF0); send(8'h58);
    scan_code = 8'h1C;
    scan_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 scan_valid = 1'b0;
    flush = 1'b0;
    row_at("flush_wins", 8'h00, 8'hFF);
    send(8'hE0); send(8'h75);
    row_at("up_col2", 8'hFB, 8'h7F);
    check("up_ctrl", control_n, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_brk_ctrl", control_n, 1'b1);
    row_at("up_brk_row", 8'h00, 8'hFF);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    row_at("pause_row", 8'h00, 8'hFF);
    check("pause_ctrl", control_n, 1'b1);
    send(8'h29);
    row_at("space_col3", 8'hF7, 8'h7F);
    send(8'h5A);
    row_at("enter_col3", 8'hF7, 8'h3F);
    do_flush();
    send(8'hF0);
    do_flush();
    send(8'h1C);
    row_at("brk_abort", 8'hFE, 8'hFD);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    row_at("typematic", 8'h00, 8'hFF);
    send(8'h14);
    check("lctrl", control_n, 1'b0);
    send(8'hF0); send(8'h14);
    check("lctrl_rel", control_n, 1'b1);
    send(8'h66);
    check("bksp_ctrl", control_n, 1'b0);
    row_at("bksp_row", 8'hFE, 8'hFD);
    send(8'hAA);
    send(8'hF0); send(8'h66);
    check("filler_bksp_brk", control_n, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
